// File: rtl/display_arbiter_pkg.sv
// Shared types and default timing constants for the display arbiter.
// State encoding is fixed at two bits so it can be traced directly on a logic analyser.
package display_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    OWN   = 2'd2
  } state_t;

  localparam int HOLD_CYC_DEF  = 50000;
  localparam int BLANK_CYC_DEF = 1000;

endpackage

// File: rtl/display_arbiter_if.sv
// Bundle of requester inputs and driver-side outputs of the display arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface display_arbiter_if #(
  parameter int NREQ = 3
);

  logic [NREQ-1:0]     req;
  logic [128*NREQ-1:0] matrix_in;
  logic [32*NREQ-1:0]  numbers_in;
  logic [NREQ-1:0]     beep_in;

  logic [127:0]        matrix_o;
  logic [31:0]         numbers_o;
  logic                beep_o;
  logic [NREQ-1:0]     grant_o;
  logic                busy_o;

  modport slave (
    input  req, matrix_in, numbers_in, beep_in,
    output matrix_o, numbers_o, beep_o, grant_o, busy_o
  );

  modport master (
    output req, matrix_in, numbers_in, beep_in,
    input  matrix_o, numbers_o, beep_o, grant_o, busy_o
  );

endinterface

// File: rtl/display_arbiter_prio_pick.sv
// Highest-index-wins picker: one-hot of the top set bit, its binary index, and an any-set flag.
// Purely combinational; an all-zero input yields all-zero outputs.
module disp_prio_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_vec,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = |i_vec;
    // Ascending scan so the last hit, the highest index, is the one kept.
    for (int i = 0; i < N; i++) begin
      if (i_vec[i]) begin
        o_onehot    = '0;
        o_onehot[i] = 1'b1;
        o_idx       = IW'(i);
      end
    end
  end

endmodule

// File: rtl/display_arbiter.sv
// Shares the LED matrix, digit display and beeper among NREQ controllers with fixed priority,
// a minimum hold time per owner and a blank gap on every hand-over.
module display_arbiter
  import display_arbiter_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int HOLD_CYC  = HOLD_CYC_DEF,
  parameter int BLANK_CYC = BLANK_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  display_arbiter_if.slave bus
);

  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CMAX = (HOLD_CYC > BLANK_CYC) ? HOLD_CYC : BLANK_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] LP_HOLD_LOAD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] LP_BLANK_LOAD = CW'(BLANK_CYC - 1);

  state_t          r_state;
  logic [CW-1:0]   r_hold_cnt;
  logic [CW-1:0]   r_blank_cnt;
  logic [IW-1:0]   r_owner;
  logic [NREQ-1:0] r_grant;
  logic [127:0]    r_matrix;
  logic [31:0]     r_numbers;
  logic            r_beep;
  logic            r_busy;

  logic [NREQ-1:0] w_win_onehot;
  logic [IW-1:0]   w_win_idx;
  logic            w_any;
  logic            w_owner_req;
  logic            w_higher;
  logic [127:0]    w_mat_sl [NREQ];
  logic [31:0]     w_num_sl [NREQ];
  logic [127:0]    w_own_mat;
  logic [31:0]     w_own_num;
  logic            w_own_beep;

  disp_prio_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_pick (
    .i_vec    (bus.req),
    .o_onehot (w_win_onehot),
    .o_idx    (w_win_idx),
    .o_any    (w_any)
  );

  // The overall winner outranks the owner exactly when some higher-index request is up.
  assign w_owner_req = |(bus.req & r_grant);
  assign w_higher    = w_any && (w_win_idx > r_owner);

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign w_mat_sl[gi] = bus.matrix_in[128*gi +: 128];
      assign w_num_sl[gi] = bus.numbers_in[32*gi +: 32];
    end
  endgenerate

  always_comb begin
    w_own_mat  = '0;
    w_own_num  = '0;
    w_own_beep = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_owner == IW'(i)) begin
        w_own_mat  = w_mat_sl[i];
        w_own_num  = w_num_sl[i];
        w_own_beep = bus.beep_in[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_hold_cnt  <= '0;
      r_blank_cnt <= '0;
      r_owner     <= '0;
      r_grant     <= '0;
      r_matrix    <= '0;
      r_numbers   <= '0;
      r_beep      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      // Display outputs are dark unless the OWN branch below keeps an owner on.
      r_matrix  <= '0;
      r_numbers <= '0;
      r_beep    <= 1'b0;
      case (r_state)
        IDLE: begin
          r_grant <= '0;
          if (w_any) begin
            r_state     <= BLANK;
            r_blank_cnt <= LP_BLANK_LOAD;
            r_busy      <= 1'b1;
          end else begin
            r_busy <= 1'b0;
          end
        end
        BLANK: begin
          r_grant <= '0;
          if (r_blank_cnt == '0) begin
            if (w_any) begin
              r_state    <= OWN;
              r_owner    <= w_win_idx;
              r_grant    <= w_win_onehot;
              r_hold_cnt <= LP_HOLD_LOAD;
              r_busy     <= 1'b1;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_blank_cnt <= r_blank_cnt - CW'(1);
          end
        end
        OWN: begin
          if (!w_owner_req || (w_higher && (r_hold_cnt == '0))) begin
            r_state     <= BLANK;
            r_blank_cnt <= LP_BLANK_LOAD;
            r_grant     <= '0;
            r_busy      <= 1'b1;
          end else begin
            r_matrix  <= w_own_mat;
            r_numbers <= w_own_num;
            r_beep    <= w_own_beep;
            if (r_hold_cnt != '0) begin
              r_hold_cnt <= r_hold_cnt - CW'(1);
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.matrix_o  = r_matrix;
  assign bus.numbers_o = r_numbers;
  assign bus.beep_o    = r_beep;
  assign bus.grant_o   = r_grant;
  assign bus.busy_o    = r_busy;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter (NREQ=3, HOLD_CYC=8, BLANK_CYC=2) with a per-edge
// scoreboard of expected grant/busy/beep/matrix/numbers values.
module tb_display_arbiter;

  localparam int NREQ = 3;

  logic clk;
  logic rst_n;

  display_arbiter_if #(.NREQ(NREQ)) bus ();

  display_arbiter #(
    .NREQ      (NREQ),
    .HOLD_CYC  (8),
    .BLANK_CYC (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [127:0] m_sl [NREQ];
  logic [31:0]  n_sl [NREQ];

  assign bus.matrix_in  = {m_sl[2], m_sl[1], m_sl[0]};
  assign bus.numbers_in = {n_sl[2], n_sl[1], n_sl[0]};

  typedef struct packed {
    logic [2:0]   grant;
    logic         busy;
    logic         beep;
    logic [127:0] mat;
    logic [31:0]  num;
  } exp_t;

  exp_t  sb[$];
  string tag_q[$];
  int    errors = 0;
  int    checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input string field, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s.%s: got %0h expected %0h", tag, field, obs, expv);
    end
  endtask

  task automatic compare(input string tag, input exp_t e);
    chk(tag, "grant",   128'(bus.grant_o),   128'(e.grant));
    chk(tag, "busy",    128'(bus.busy_o),    128'(e.busy));
    chk(tag, "beep",    128'(bus.beep_o),    128'(e.beep));
    chk(tag, "matrix",  bus.matrix_o,        e.mat);
    chk(tag, "numbers", 128'(bus.numbers_o), 128'(e.num));
  endtask

  // Push the expectation for the coming edge, advance one edge, pop and compare.
  task automatic tick(input string tag, input logic [2:0] g, input logic b, input logic bp,
                      input logic [127:0] m, input logic [31:0] n);
    exp_t e;
    exp_t got;
    string t;
    e.grant = g;
    e.busy  = b;
    e.beep  = bp;
    e.mat   = m;
    e.num   = n;
    sb.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    t   = tag_q.pop_front();
    compare(t, got);
  endtask

  task automatic t_idle(input string tag);
    tick(tag, 3'b000, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic t_blank(input string tag);
    tick(tag, 3'b000, 1'b1, 1'b0, '0, '0);
  endtask

  task automatic t_enter(input string tag, input int k);
    tick(tag, 3'(1 << k), 1'b1, 1'b0, '0, '0);
  endtask

  task automatic t_data(input string tag, input int k);
    tick(tag, 3'(1 << k), 1'b1, bus.beep_in[k], m_sl[k], n_sl[k]);
  endtask

  initial begin
    exp_t zero_e;
    zero_e      = '0;
    rst_n       = 1'b0;
    bus.req     = '0;
    bus.beep_in = '0;
    m_sl[0] = {16{8'hA5}};
    m_sl[1] = {16{8'h3C}};
    m_sl[2] = {16{8'h5A}};
    n_sl[0] = 32'h1111_0000;
    n_sl[1] = 32'h2222_0001;
    n_sl[2] = 32'h3333_0002;

    repeat (2) @(posedge clk);
    #1;
    compare("reset", zero_e);
    rst_n = 1'b1;
    t_idle("idle_no_req");

    // Simple grant of requester 0
    bus.req     = 3'b001;
    bus.beep_in = 3'b001;
    t_blank("A_blank1");
    t_blank("A_blank2");
    t_enter("A_grant", 0);
    t_data("A_data", 0);
    m_sl[0] = {16{8'h0F}};
    t_data("A_newslice", 0);

    // Asynchronous reset in the middle of ownership
    rst_n = 1'b0;
    #1;
    compare("B_async_rst", zero_e);
    @(posedge clk);
    #1;
    compare("B_rst_held", zero_e);
    rst_n = 1'b1;
    t_blank("B_blank1");
    t_blank("B_blank2");
    t_enter("B_grant", 0);

    // Hold then preempt by requester 2
    bus.req     = 3'b101;
    bus.beep_in = 3'b101;
    m_sl[0]     = {16{8'hA5}};
    for (int i = 1; i <= 7; i++) begin
      t_data($sformatf("C_hold%0d", i), 0);
    end
    t_blank("C_blank1");
    t_blank("C_blank2");
    t_enter("C_grant2", 2);
    t_data("C_data2", 2);

    // Owner 2 drops its request with hold time remaining
    t_data("D_hold5", 2);
    bus.req = 3'b001;
    t_blank("D_blank1");
    t_blank("D_blank2");
    t_enter("D_grant0", 0);
    t_data("D_data0", 0);

    // Lower-index request never preempts
    bus.req = 3'b010;
    t_blank("E_blank1");
    t_blank("E_blank2");
    t_enter("E_grant1", 1);
    t_data("E_data1", 1);
    bus.req = 3'b011;
    for (int i = 0; i < 20; i++) begin
      t_data($sformatf("E_low%0d", i), 1);
    end
    bus.req = 3'b000;
    t_blank("E_drop1");
    t_blank("E_drop2");
    t_idle("E_idle1");
    t_idle("E_idle2");

    // Requests changing during the blank gap
    bus.req = 3'b100;
    t_blank("F_blank1");
    bus.req = 3'b010;
    t_blank("F_blank2");
    t_enter("F_grant1", 1);
    t_data("F_data1", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
